sdram_burst_responder: RTL and testbench

//  Responder end of the sdram_clk burst-read interface used by the graphics fetch path
//  (burst_rd/addr/len/32bit in; burst_data/valid/done out). Accepts one burst request,

---
 rtl/sdram_burst_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_sdram_burst_responder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_responder.sv
// sdram_burst_responder
//  Responder end of the sdram_clk burst-read interface. Accepts one burst request,
//  issues 16-bit reads to the SDRAM core port (bounded number in flight) and returns
//  the data as 16-bit beats or packed 32-bit beats (first halfword in [31:16]).
//  Optional feature: define PENDING_REQ_EN to add a one-deep pending request slot so a
//  request arriving while busy is served right after the current burst.
module sdram_burst_responder #(
   parameter int MEM_AW          = 25,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic              sdram_clk,
   input  logic              nRESET,
   input  logic              burst_rd,
   input  logic [25:0]       burst_addr,
   input  logic [10:0]       burst_len,
   input  logic              burst_32bit,
   output logic [31:0]       burst_data,
   output logic              burst_data_valid,
   output logic              burst_data_done,
   output logic              busy,
   output logic              mem_rd,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_rvalid
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUTSTANDING);

   state_t      state_r;
   logic        mode_r;
   logic [11:0] total_r;
   logic [11:0] issued_r;
   logic [11:0] returned_r;
   logic [3:0]  outst_r;
   logic [15:0] hold_r;

   logic        hs_s;
   logic        acc_rv_s;
   logic [11:0] issued_n_s;
   logic [11:0] returned_n_s;
   logic [3:0]  outst_n_s;

   logic        ld_go_s;
   logic [24:0] ld_addr_s;
   logic [10:0] ld_len_s;
   logic        ld_32_s;
   logic [11:0] ld_total_s;

   // Byte-lane select bit is meaningless for halfword accesses
   logic        addr_lsb_unused_s;
   assign addr_lsb_unused_s = burst_addr[0];

`ifdef PENDING_REQ_EN
   logic        slot_vld_r;
   logic [24:0] slot_addr_r;
   logic [10:0] slot_len_r;
   logic        slot_32_r;
   logic        slot_cap_s;
   logic        slot_take_s;

   // Decide whether the slot captures a request or is consumed this cycle
   always_comb begin
      slot_take_s = (state_r == ST_DONE) && slot_vld_r;
      if (burst_rd && (state_r != ST_IDLE) && !((state_r == ST_DONE) && !slot_vld_r)) begin
         slot_cap_s = 1'b1;
      end else begin
         slot_cap_s = 1'b0;
      end
   end

   // One-deep pending slot; a request arriving while it is full is dropped
   always_ff @(posedge sdram_clk or negedge nRESET) begin
      if (!nRESET) begin
         slot_vld_r  <= 1'b0;
         slot_addr_r <= 25'd0;
         slot_len_r  <= 11'd0;
         slot_32_r   <= 1'b0;
      end else if (slot_cap_s && (!slot_vld_r || slot_take_s)) begin
         slot_vld_r  <= 1'b1;
         slot_addr_r <= burst_addr[25:1];
         slot_len_r  <= burst_len;
         slot_32_r   <= burst_32bit;
      end else if (slot_take_s) begin
         slot_vld_r  <= 1'b0;
      end else begin
         slot_vld_r  <= slot_vld_r;
      end
   end
`endif

   // Select the request (fresh or pending) that starts a burst this cycle
   always_comb begin
      ld_go_s   = 1'b0;
      ld_addr_s = burst_addr[25:1];
      ld_len_s  = burst_len;
      ld_32_s   = burst_32bit;
      case (state_r)
         ST_IDLE: ld_go_s = burst_rd;
         ST_DONE: begin
`ifdef PENDING_REQ_EN
            if (slot_vld_r) begin
               ld_go_s   = 1'b1;
               ld_addr_s = slot_addr_r;
               ld_len_s  = slot_len_r;
               ld_32_s   = slot_32_r;
            end else begin
               ld_go_s   = burst_rd;
            end
`else
            ld_go_s = 1'b0;
`endif
         end
         default: ld_go_s = 1'b0;
      endcase
      if (ld_32_s) begin
         ld_total_s = {ld_len_s, 1'b0};
      end else begin
         ld_total_s = {1'b0, ld_len_s};
      end
   end

   // Core handshake, accepted returns and the counter values after this edge
   always_comb begin
      hs_s = mem_rd & mem_ready;
      if ((state_r == ST_RUN) && mem_rvalid && (outst_r != 4'd0)) begin
         acc_rv_s = 1'b1;
      end else begin
         acc_rv_s = 1'b0;
      end
      issued_n_s   = issued_r + {11'd0, hs_s};
      returned_n_s = returned_r + {11'd0, acc_rv_s};
      outst_n_s    = outst_r + {3'd0, hs_s} - {3'd0, acc_rv_s};
   end

   // Burst FSM: counters, return packing and all registered outputs
   always_ff @(posedge sdram_clk or negedge nRESET) begin
      if (!nRESET) begin
         state_r          <= ST_IDLE;
         mode_r           <= 1'b0;
         total_r          <= 12'd0;
         issued_r         <= 12'd0;
         returned_r       <= 12'd0;
         outst_r          <= 4'd0;
         hold_r           <= 16'd0;
         burst_data       <= 32'd0;
         burst_data_valid <= 1'b0;
         burst_data_done  <= 1'b0;
         busy             <= 1'b0;
         mem_rd           <= 1'b0;
         mem_addr         <= '0;
      end else begin
         burst_data_valid <= 1'b0;
         burst_data_done  <= (state_r == ST_DONE);
         if (ld_go_s) begin
            mode_r     <= ld_32_s;
            total_r    <= ld_total_s;
            mem_addr   <= MEM_AW'(ld_addr_s);
            issued_r   <= 12'd0;
            returned_r <= 12'd0;
            outst_r    <= 4'd0;
            busy       <= 1'b1;
            if (ld_total_s == 12'd0) begin
               state_r <= ST_DONE;
               mem_rd  <= 1'b0;
            end else begin
               state_r <= ST_RUN;
               mem_rd  <= 1'b1;
            end
         end else begin
            case (state_r)
               ST_IDLE: begin
                  busy   <= 1'b0;
                  mem_rd <= 1'b0;
               end
               ST_RUN: begin
                  if (hs_s) begin
                     mem_addr <= mem_addr + MEM_AW'(1);
                  end
                  issued_r   <= issued_n_s;
                  returned_r <= returned_n_s;
                  outst_r    <= outst_n_s;
                  if (acc_rv_s) begin
                     if (!mode_r) begin
                        burst_data       <= {16'h0000, mem_rdata};
                        burst_data_valid <= 1'b1;
                     end else if (!returned_r[0]) begin
                        hold_r <= mem_rdata;
                     end else begin
                        burst_data       <= {hold_r, mem_rdata};
                        burst_data_valid <= 1'b1;
                     end
                  end
                  // Final return lands this edge: its beat and the DONE state appear together
                  if (returned_n_s == total_r) begin
                     state_r <= ST_DONE;
                     mem_rd  <= 1'b0;
                  end else begin
                     mem_rd  <= (issued_n_s < total_r) && (outst_n_s < MAX_OUT_C);
                  end
               end
               ST_DONE: begin
                  state_r <= ST_IDLE;
                  busy    <= 1'b0;
                  mem_rd  <= 1'b0;
               end
               default: begin
                  state_r <= ST_IDLE;
                  busy    <= 1'b0;
                  mem_rd  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sdram_burst_responder.sv
// Scoreboard bench for sdram_burst_responder: the stimulus pushes expected core
// addresses and beats into queues; a core model and a beat monitor pop and compare.
module tb_sdram_burst_responder;

   localparam int MEM_AW = 25;
   localparam int MAXO   = 4;

   logic              sdram_clk = 1'b0;
   logic              nRESET = 1'b0;
   logic              burst_rd = 1'b0;
   logic [25:0]       burst_addr = 26'd0;
   logic [10:0]       burst_len = 11'd0;
   logic              burst_32bit = 1'b0;
   logic [31:0]       burst_data;
   logic              burst_data_valid;
   logic              burst_data_done;
   logic              busy;
   logic              mem_rd;
   logic [MEM_AW-1:0] mem_addr;
   logic              mem_ready = 1'b0;
   logic [15:0]       mem_rdata = 16'd0;
   logic              mem_rvalid = 1'b0;

   sdram_burst_responder #(.MEM_AW(MEM_AW), .MAX_OUTSTANDING(MAXO)) dut (
      .sdram_clk(sdram_clk), .nRESET(nRESET), .burst_rd(burst_rd),
      .burst_addr(burst_addr), .burst_len(burst_len), .burst_32bit(burst_32bit),
      .burst_data(burst_data), .burst_data_valid(burst_data_valid),
      .burst_data_done(burst_data_done), .busy(busy), .mem_rd(mem_rd),
      .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .mem_rvalid(mem_rvalid)
   );

   always #5 sdram_clk = ~sdram_clk;

   int cyc = 0;
   always @(posedge sdram_clk) cyc++;

   int total_cnt = 0;
   int bad_cnt = 0;

   logic [31:0]       exp_beat_q[$];
   logic [MEM_AW-1:0] exp_addr_q[$];
   logic [15:0]       rd_q[$];
   int                due_q[$];

   int hs_cnt = 0, rv_cnt = 0, max_out = 0;
   int rdelay = 1, stall_idx = -1, stall_left = 0;
   logic stalled = 1'b0, stray_req = 1'b0;
   logic [MEM_AW-1:0] stall_addr = '0;
   int done_cnt = 0, beats_seen = 0, last_valid_cyc = 0, rd_cyc = 0;
   logic zero_len = 1'b0, chk_busy_done = 1'b1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // SDRAM core model: grants reads, checks addresses, returns data in order
   always @(negedge sdram_clk) begin
      int outv;
      if (!nRESET) begin
         mem_ready  = 1'b0;
         mem_rvalid = 1'b0;
         stalled    = 1'b0;
      end else begin
         if (stalled) begin
            check("mem_rd_held", mem_rd, 1'b1);
            check("mem_addr_held", mem_addr, stall_addr);
         end
         stalled = 1'b0;
         if (stray_req) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'hDEAD;
            stray_req  = 1'b0;
         end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            mem_rvalid = 1'b1;
            mem_rdata  = (rd_q.size() > 0) ? rd_q.pop_front() : 16'hEEEE;
            rv_cnt++;
         end else begin
            mem_rvalid = 1'b0;
         end
         if (mem_rd) begin
            if (hs_cnt == stall_idx && stall_left > 0) begin
               mem_ready  = 1'b0;
               stall_left--;
               stalled    = 1'b1;
               stall_addr = mem_addr;
            end else begin
               mem_ready = 1'b1;
               hs_cnt++;
               if (exp_addr_q.size() == 0) begin
                  total_cnt++;
                  bad_cnt++;
                  $display("FAIL unexpected_read: got addr %0h expected none", mem_addr);
               end else begin
                  check("mem_addr", mem_addr, exp_addr_q.pop_front());
               end
               due_q.push_back(cyc + rdelay);
               outv = hs_cnt - rv_cnt;
               check("outstanding_limit", outv <= MAXO, 1'b1);
               if (outv > max_out) max_out = outv;
            end
         end else begin
            mem_ready = 1'b0;
         end
      end
   end

   // Beat and done monitor
   always @(negedge sdram_clk) begin
      if (nRESET) begin
         if (burst_data_valid) begin
            beats_seen++;
            last_valid_cyc = cyc;
            if (exp_beat_q.size() == 0) begin
               total_cnt++;
               bad_cnt++;
               $display("FAIL unexpected_beat: got %0h expected none", burst_data);
            end else begin
               check("beat_data", burst_data, exp_beat_q.pop_front());
            end
         end
         if (burst_data_done) begin
            done_cnt++;
            if (chk_busy_done) check("busy_low_with_done", busy, 1'b0);
            if (zero_len) check("done_latency_len0", cyc - rd_cyc, 2);
            else          check("done_after_last_beat", cyc - last_valid_cyc, 1);
         end
      end
   end

   task automatic prep();
      hs_cnt = 0;
      rv_cnt = 0;
      max_out = 0;
   endtask

   task automatic start_burst(input logic [25:0] a, input logic [10:0] l, input logic m);
      @(negedge sdram_clk);
      burst_rd = 1'b1;
      burst_addr = a;
      burst_len = l;
      burst_32bit = m;
      rd_cyc = cyc;
      @(negedge sdram_clk);
      burst_rd = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(negedge sdram_clk);
         n++;
      end
      check("done_within_budget", done_cnt >= target, 1'b1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_data"}, burst_data, 32'd0);
      check({tag, "_valid"}, burst_data_valid, 1'b0);
      check({tag, "_done"}, burst_data_done, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_mem_rd"}, mem_rd, 1'b0);
      check({tag, "_mem_addr"}, mem_addr, 25'd0);
   endtask

   initial begin
      int done_target;
      int beats_before;
      done_target = 0;

      repeat (3) @(negedge sdram_clk);
      check_outputs_zero("reset");
      nRESET = 1'b1;
      repeat (2) @(negedge sdram_clk);

      // 32-bit, addr 0x100, len 2
      prep();
      for (int i = 0; i < 4; i++) exp_addr_q.push_back(25'h80 + 25'(i));
      rd_q.push_back(16'h1111); rd_q.push_back(16'h2222);
      rd_q.push_back(16'h3333); rd_q.push_back(16'h4444);
      exp_beat_q.push_back(32'h11112222);
      exp_beat_q.push_back(32'h33334444);
      start_burst(26'h100, 11'd2, 1'b1);
      check("busy_after_accept", busy, 1'b1);
      done_target++;
      wait_done(done_target, 200);
      repeat (2) @(negedge sdram_clk);
      check("busy_after_done", busy, 1'b0);
      check("t1_beats_left", exp_beat_q.size(), 0);

      // 16-bit, len 3, 2nd read stalled 5 cycles
      prep();
      stall_idx = 1;
      stall_left = 5;
      for (int i = 0; i < 3; i++) exp_addr_q.push_back(25'h100 + 25'(i));
      rd_q.push_back(16'hAAAA); rd_q.push_back(16'hBBBB); rd_q.push_back(16'hCCCC);
      exp_beat_q.push_back(32'h0000AAAA);
      exp_beat_q.push_back(32'h0000BBBB);
      exp_beat_q.push_back(32'h0000CCCC);
      start_burst(26'h200, 11'd3, 1'b0);
      done_target++;
      wait_done(done_target, 200);
      repeat (2) @(negedge sdram_clk);
      stall_idx = -1;
      check("t2_beats_left", exp_beat_q.size(), 0);
      check("t2_stall_used", stall_left, 0);

      // 32-bit, len 8, returns delayed 10 cycles; extra request while busy
      prep();
      rdelay = 10;
      for (int i = 0; i < 16; i++) begin
         exp_addr_q.push_back(25'h800 + 25'(i));
         rd_q.push_back(16'h0100 + 16'(i));
      end
      for (int k = 0; k < 8; k++)
         exp_beat_q.push_back({16'h0100 + 16'(2 * k), 16'h0101 + 16'(2 * k)});
`ifdef PENDING_REQ_EN
      chk_busy_done = 1'b0;
      exp_addr_q.push_back(25'h20); exp_addr_q.push_back(25'h21);
      rd_q.push_back(16'h0A0B); rd_q.push_back(16'h0C0D);
      exp_beat_q.push_back(32'h00000A0B);
      exp_beat_q.push_back(32'h00000C0D);
`endif
      start_burst(26'h1000, 11'd8, 1'b1);
      repeat (3) @(negedge sdram_clk);
      start_burst(26'h40, 11'd2, 1'b0);
`ifdef PENDING_REQ_EN
      done_target += 2;
`else
      done_target += 1;
`endif
      wait_done(done_target, 600);
      repeat (30) @(negedge sdram_clk);
      chk_busy_done = 1'b1;
      check("t3_done_count", done_cnt, done_target);
      check("t3_max_outstanding", max_out, MAXO);
      check("t3_beats_left", exp_beat_q.size(), 0);
      check("t3_addrs_left", exp_addr_q.size(), 0);
`ifdef PENDING_REQ_EN
      check("t3_reads", hs_cnt, 18);
`else
      check("t3_reads", hs_cnt, 16);
`endif
      rdelay = 1;

      // len 0: no read, no beat, done two cycles after request
      prep();
      beats_before = beats_seen;
      zero_len = 1'b1;
      start_burst(26'h300, 11'd0, 1'b1);
      done_target++;
      wait_done(done_target, 20);
      repeat (3) @(negedge sdram_clk);
      zero_len = 1'b0;
      check("len0_reads", hs_cnt, 0);
      check("len0_beats", beats_seen - beats_before, 0);

      // Address wrap at the top of the core address space
      prep();
      exp_addr_q.push_back(25'h1FFFFFF);
      exp_addr_q.push_back(25'h0000000);
      rd_q.push_back(16'h5A5A); rd_q.push_back(16'hC3C3);
      exp_beat_q.push_back(32'h5A5AC3C3);
      start_burst(26'h3FFFFFE, 11'd1, 1'b1);
      done_target++;
      wait_done(done_target, 100);
      repeat (2) @(negedge sdram_clk);
      check("wrap_beats_left", exp_beat_q.size(), 0);

      // Asynchronous reset mid-burst, then a stray return
      prep();
      rdelay = 3;
      for (int i = 0; i < 4; i++) begin
         exp_addr_q.push_back(25'h200 + 25'(i));
         rd_q.push_back(16'h0001 + 16'(i));
         exp_beat_q.push_back(32'h00000001 + 32'(i));
      end
      start_burst(26'h400, 11'd4, 1'b0);
      repeat (2) @(negedge sdram_clk);
      #3;
      nRESET = 1'b0;
      #1;
      check_outputs_zero("midreset");
      exp_addr_q.delete();
      exp_beat_q.delete();
      rd_q.delete();
      due_q.delete();
      prep();
      repeat (3) @(negedge sdram_clk);
      beats_before = beats_seen;
      nRESET = 1'b1;
      stray_req = 1'b1;
      repeat (6) @(negedge sdram_clk);
      check("stray_no_beat", beats_seen - beats_before, 0);
      check("stray_busy", busy, 1'b0);
      check("stray_mem_rd", mem_rd, 1'b0);
      check("stray_no_done", done_cnt, done_target);
      rdelay = 1;

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
